// File: rtl/i2c_config_seq.sv
// Power-up configuration sequencer: walks a ROM table of 24-bit I2C words,
// sends each through i2c_send with NACK retry and hang timeout, and reports
// busy/done/error status to the system.
module i2c_config_seq #(
    parameter int unsigned NUM_WORDS  = 11,
    parameter int unsigned ADDR_W     = 4,
    parameter int unsigned PWR_DELAY  = 50000,
    parameter int unsigned MAX_RETRY  = 3,
    parameter int unsigned TIMEOUT    = 8191,
    parameter int unsigned AUTO_START = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [23:0]       rom_data,
    output logic              i2c_start,
    output logic [23:0]       i2c_data,
    input  logic              i2c_done,
    input  logic              i2c_ack,
    output logic              cfg_busy,
    output logic              cfg_done,
    output logic              cfg_err,
    output logic [ADDR_W-1:0] err_index
);

    localparam int unsigned PWR_LAST = (PWR_DELAY > 0) ? PWR_DELAY - 1 : 0;
    localparam int unsigned PWR_W    = (PWR_DELAY > 1) ? $clog2(PWR_DELAY) : 1;
    localparam int unsigned TO_LAST  = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam int unsigned TO_W     = ($clog2(TIMEOUT) > 2) ? $clog2(TIMEOUT) : 2;
    localparam int unsigned RTY_W    = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);
    // i2c_send must drop done within this many cycles of accepting start
    localparam logic [TO_W-1:0]   BUSY_LAST = TO_W'(3);

    typedef enum logic [3:0] {
        IDLE, PWR_WAIT, FETCH, LOAD, START,
        WAIT_BUSY, WAIT_DONE, CHECK, FINISH, FAIL
    } state_t;

    state_t            state, state_nxt;
    logic [PWR_W-1:0]  pwr_cnt, pwr_cnt_nxt;
    logic [TO_W-1:0]   to_cnt, to_cnt_nxt;
    logic [RTY_W-1:0]  retry_cnt, retry_cnt_nxt;
    logic              ack_q, ack_q_nxt;
    logic              auto_pend;
    logic [ADDR_W-1:0] rom_addr_nxt, err_index_nxt;
    logic [23:0]       i2c_data_nxt;
    logic              i2c_start_nxt, cfg_busy_nxt, cfg_done_nxt, cfg_err_nxt;
    logic              run_req, last_word, retry_left;

    assign run_req    = go | auto_pend;
    assign last_word  = (rom_addr == LAST_ADDR);
    assign retry_left = (32'(retry_cnt) < MAX_RETRY);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (run_req) state_nxt = PWR_WAIT;
            PWR_WAIT:  if (32'(pwr_cnt) == PWR_LAST) state_nxt = FETCH;
            FETCH:     state_nxt = LOAD;
            LOAD:      state_nxt = START;
            START:     if (i2c_start) state_nxt = WAIT_BUSY;
            WAIT_BUSY: begin
                if (!i2c_done)                 state_nxt = WAIT_DONE;
                else if (to_cnt == BUSY_LAST)  state_nxt = FAIL;
            end
            WAIT_DONE: begin
                if (i2c_done)                     state_nxt = CHECK;
                else if (32'(to_cnt) == TO_LAST)  state_nxt = FAIL;
            end
            CHECK: begin
                if (ack_q)           state_nxt = last_word ? FINISH : FETCH;
                else if (retry_left) state_nxt = START;
                else                 state_nxt = FAIL;
            end
            FINISH:    state_nxt = IDLE;
            FAIL:      state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Output and datapath decode (next values of the registered outputs)
    always_comb begin
        rom_addr_nxt  = rom_addr;
        err_index_nxt = err_index;
        i2c_data_nxt  = i2c_data;
        i2c_start_nxt = 1'b0;
        cfg_busy_nxt  = cfg_busy;
        cfg_done_nxt  = cfg_done;
        cfg_err_nxt   = cfg_err;
        pwr_cnt_nxt   = '0;
        to_cnt_nxt    = '0;
        retry_cnt_nxt = retry_cnt;
        ack_q_nxt     = ack_q;
        case (state)
            IDLE: begin
                if (run_req) begin
                    cfg_done_nxt  = 1'b0;
                    cfg_err_nxt   = 1'b0;
                    err_index_nxt = '0;
                    rom_addr_nxt  = '0;
                    cfg_busy_nxt  = 1'b1;
                end
            end
            PWR_WAIT:  pwr_cnt_nxt = pwr_cnt + 1'b1;
            LOAD: begin
                i2c_data_nxt  = rom_data;
                retry_cnt_nxt = '0;
            end
            // one-cycle strobe, only once the sender is idle
            START:     i2c_start_nxt = i2c_done & ~i2c_start;
            WAIT_BUSY: if (i2c_done) to_cnt_nxt = to_cnt + 1'b1;
            WAIT_DONE: begin
                if (!i2c_done) to_cnt_nxt = to_cnt + 1'b1;
                else           ack_q_nxt  = i2c_ack;
            end
            CHECK: begin
                if (ack_q) begin
                    if (!last_word) rom_addr_nxt = rom_addr + 1'b1;
                end else if (retry_left) begin
                    retry_cnt_nxt = retry_cnt + 1'b1;
                end
            end
            FINISH: begin
                cfg_done_nxt = 1'b1;
                cfg_busy_nxt = 1'b0;
            end
            FAIL: begin
                cfg_err_nxt   = 1'b1;
                err_index_nxt = rom_addr;
                cfg_busy_nxt  = 1'b0;
            end
            default: ;
        endcase
    end

    // Output and datapath registers; auto_pend fakes a go right after reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rom_addr  <= '0;
            err_index <= '0;
            i2c_data  <= '0;
            i2c_start <= 1'b0;
            cfg_busy  <= 1'b0;
            cfg_done  <= 1'b0;
            cfg_err   <= 1'b0;
            pwr_cnt   <= '0;
            to_cnt    <= '0;
            retry_cnt <= '0;
            ack_q     <= 1'b0;
            auto_pend <= 1'(AUTO_START);
        end else begin
            rom_addr  <= rom_addr_nxt;
            err_index <= err_index_nxt;
            i2c_data  <= i2c_data_nxt;
            i2c_start <= i2c_start_nxt;
            cfg_busy  <= cfg_busy_nxt;
            cfg_done  <= cfg_done_nxt;
            cfg_err   <= cfg_err_nxt;
            pwr_cnt   <= pwr_cnt_nxt;
            to_cnt    <= to_cnt_nxt;
            retry_cnt <= retry_cnt_nxt;
            ack_q     <= ack_q_nxt;
            auto_pend <= 1'b0;
        end
    end

endmodule

// File: tb/tb_i2c_config_seq.sv
// Self-checking bench for i2c_config_seq: scenario table driven through
// reset/auto-start, plus hand-written reset-abort and go-handling sequences.
module tb_i2c_config_seq;

    localparam int T_OUT = 40;
    localparam logic [23:0] W0 = 24'h341E00;
    localparam logic [23:0] W1 = 24'h340C00;
    localparam logic [23:0] W2 = 24'h341201;

    logic        clk, rst, go;
    logic [3:0]  rom_addr, err_index;
    logic [23:0] rom_data, i2c_data;
    logic        i2c_start, i2c_done, i2c_ack;
    logic        cfg_busy, cfg_done, cfg_err;

    i2c_config_seq #(
        .NUM_WORDS(3), .ADDR_W(4), .PWR_DELAY(10),
        .MAX_RETRY(3), .TIMEOUT(T_OUT), .AUTO_START(1)
    ) dut (
        .clk(clk), .rst(rst), .go(go),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .i2c_start(i2c_start), .i2c_data(i2c_data),
        .i2c_done(i2c_done), .i2c_ack(i2c_ack),
        .cfg_busy(cfg_busy), .cfg_done(cfg_done),
        .cfg_err(cfg_err), .err_index(err_index)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int rel_cyc, first_start, err_cyc;
    int mode;   // slave behaviour: 0 ack all, 1 nack W1 once, 2 nack W2 always, 3 hang
    logic [23:0] tx_log[$];
    logic prev_start = 1'b0, prev_err = 1'b0;

    // Synchronous ROM, one cycle latency
    logic [23:0] rom_mem [16];
    initial begin
        for (int i = 0; i < 16; i++) rom_mem[i] = 24'hFFFFFF;
        rom_mem[0] = W0; rom_mem[1] = W1; rom_mem[2] = W2;
    end
    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    // i2c_send model: done drops the cycle after start, returns 5 cycles later
    logic s_done, s_ack, s_pend, s_hung;
    int   s_cnt, w1_seen;
    assign i2c_done = s_done;
    assign i2c_ack  = s_ack;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_done <= 1'b1; s_ack <= 1'b1; s_pend <= 1'b1;
            s_hung <= 1'b0; s_cnt <= 0; w1_seen <= 0;
        end else if (!s_hung) begin
            if (s_cnt != 0) begin
                s_cnt <= s_cnt - 1;
                if (s_cnt == 1) begin s_done <= 1'b1; s_ack <= s_pend; end
            end else if (i2c_start) begin
                s_done <= 1'b0;
                s_ack  <= 1'b0;
                if (mode == 3) s_hung <= 1'b1;
                else           s_cnt  <= 5;
                s_pend <= !((mode == 1 && i2c_data == W1 && w1_seen == 0) ||
                            (mode == 2 && i2c_data == W2));
                if (i2c_data == W1) w1_seen <= w1_seen + 1;
            end
        end
    end

    // Cycle counter
    always @(posedge clk) cyc <= cyc + 1;

    // Transaction log and start-strobe width monitor
    always @(negedge clk) begin
        if (i2c_start) begin
            n_cmp++;
            if (prev_start) begin
                n_fail++;
                $display("FAIL start_width: i2c_start high 2 cycles at cyc %0d (required single cycle)", cyc);
            end
            if (tx_log.size() == 0) first_start = cyc;
            tx_log.push_back(i2c_data);
        end
        if (cfg_err && !prev_err) err_cyc = cyc;
        prev_start = i2c_start;
        prev_err   = cfg_err;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_start"},  32'(i2c_start), 0);
        check({tag, "_addr"},   32'(rom_addr),  0);
        check({tag, "_data"},   32'(i2c_data),  0);
        check({tag, "_busy"},   32'(cfg_busy),  0);
        check({tag, "_done"},   32'(cfg_done),  0);
        check({tag, "_err"},    32'(cfg_err),   0);
        check({tag, "_erridx"}, 32'(err_index), 0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tx_log.delete();
        repeat (3) @(negedge clk);
        rel_cyc = cyc;
        rst = 1'b1;
    endtask

    task automatic run_wait(input int bound, output bit ok);
        int n = 0;
        while (!cfg_busy && n < bound) begin @(negedge clk); n++; end
        while (cfg_busy && n < bound)  begin @(negedge clk); n++; end
        ok = (n < bound) && !cfg_busy;
    endtask

    typedef struct {
        int               mode;
        int               n_tx;
        logic [0:5][23:0] seq;
        logic             done;
        logic             err;
        logic [3:0]       idx;
    } vec_t;

    vec_t vecs[4];
    bit   ok;
    int   n;

    initial begin
        vecs[0] = '{mode: 0, n_tx: 3, seq: {W0, W1, W2, W0, W0, W0}, done: 1'b1, err: 1'b0, idx: 4'd0};
        vecs[1] = '{mode: 1, n_tx: 4, seq: {W0, W1, W1, W2, W0, W0}, done: 1'b1, err: 1'b0, idx: 4'd0};
        vecs[2] = '{mode: 2, n_tx: 6, seq: {W0, W1, W2, W2, W2, W2}, done: 1'b0, err: 1'b1, idx: 4'd2};
        vecs[3] = '{mode: 3, n_tx: 1, seq: {W0, W0, W0, W0, W0, W0}, done: 1'b0, err: 1'b1, idx: 4'd0};

        mode = 0;
        go   = 1'b0;
        rst  = 1'b1;
        #2 rst = 1'b0;
        #1 check_all_zero("reset");

        // Scenario table: each run is launched by auto-start after reset
        for (int v = 0; v < 4; v++) begin
            mode = vecs[v].mode;
            do_reset();
            run_wait(3000, ok);
            check($sformatf("v%0d_run_end", v), 32'(ok), 1);
            repeat (40) @(negedge clk);
            check($sformatf("v%0d_n_tx", v), tx_log.size(), vecs[v].n_tx);
            for (int i = 0; i < vecs[v].n_tx; i++)
                if (i < tx_log.size())
                    check($sformatf("v%0d_word%0d", v, i), 32'(tx_log[i]), 32'(vecs[v].seq[i]));
            check($sformatf("v%0d_done", v),   32'(cfg_done),  32'(vecs[v].done));
            check($sformatf("v%0d_err", v),    32'(cfg_err),   32'(vecs[v].err));
            check($sformatf("v%0d_erridx", v), 32'(err_index), 32'(vecs[v].idx));
            check($sformatf("v%0d_busy", v),   32'(cfg_busy),  0);
            if (v == 0)
                check("first_start_latency_ge11", 32'((first_start - rel_cyc) >= 11), 1);
            if (mode == 3)
                check("hang_err_within_timeout_plus4",
                      32'((err_cyc - first_start) > 0 && (err_cyc - first_start) <= T_OUT + 4), 1);
        end

        // Reset in the middle of transaction 2 aborts everything asynchronously
        mode = 0;
        do_reset();
        n = 0;
        while (tx_log.size() < 2 && n < 500) begin @(negedge clk); n++; end
        check("midrst_reached_tx2", 32'(tx_log.size() >= 2), 1);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1 check_all_zero("midrst");
        tx_log.delete();
        @(negedge clk);
        rst = 1'b1;
        run_wait(3000, ok);
        check("midrst_rerun_end", 32'(ok), 1);
        check("midrst_rerun_n_tx", tx_log.size(), 3);
        if (tx_log.size() > 0) check("midrst_rerun_word0", 32'(tx_log[0]), 32'(W0));
        check("midrst_rerun_done", 32'(cfg_done), 1);

        // go while busy is ignored and not queued
        do_reset();
        repeat (5) @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        run_wait(3000, ok);
        check("gobusy_run_end", 32'(ok), 1);
        repeat (40) @(negedge clk);
        check("gobusy_n_tx", tx_log.size(), 3);
        check("gobusy_done", 32'(cfg_done), 1);

        // go after done clears cfg_done next cycle and repeats the table
        tx_log.delete();
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        check("rego_done_cleared", 32'(cfg_done), 0);
        check("rego_busy", 32'(cfg_busy), 1);
        run_wait(3000, ok);
        check("rego_run_end", 32'(ok), 1);
        check("rego_n_tx", tx_log.size(), 3);
        for (int i = 0; i < 3; i++)
            if (i < tx_log.size())
                check($sformatf("rego_word%0d", i), 32'(tx_log[i]), 32'(vecs[0].seq[i]));
        check("rego_done", 32'(cfg_done), 1);
        check("rego_err", 32'(cfg_err), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Global time bound
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time bound, got timeout, required completion");
        $fatal(1);
    end

endmodule
